// File: rtl/debounce_pkg.sv
// ---------------------------------------------------------------------------
// debounce_pkg
//
// Shared definitions for the multi-channel debouncer:
//   - default parameter values used by debounce_multi and debounce_channel
//   - counter_bits(): width of the per-channel stable counter
//   - edge_kind_t: classifies what a channel accepts on the coming edge
// ---------------------------------------------------------------------------
package debounce_pkg;

    localparam int DEFAULT_NUM_CHANNELS = 4;
    localparam int DEFAULT_STABLE_TICKS = 50;
    localparam int DEFAULT_SYNC_STEPS   = 3;

    // Kind of change a channel accepts on the next clock edge
    typedef enum logic [1:0] {
        EDGE_NONE = 2'd0,
        EDGE_RISE = 2'd1,
        EDGE_FALL = 2'd2
    } edge_kind_t;

    // The counter must hold values 0..stable_ticks-1; one extra code is kept
    // so that a single-tick build still gets a 1-bit counter
    function automatic int counter_bits(input int stable_ticks);
        return (stable_ticks < 1) ? 1 : $clog2(stable_ticks + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// ---------------------------------------------------------------------------
// debounce_channel
//
// One debouncer channel: synchroniser chain, saturating stable counter,
// debounced level flop, rising/falling strobes and push-button toggle.
//
// Ports:
//   in_clk          system clock
//   in_rst          asynchronous reset, active low
//   in_signal       raw asynchronous input
//   out_debounced   accepted stable level
//   out_rising      one-cycle strobe after an accepted 0->1 change
//   out_falling     one-cycle strobe after an accepted 1->0 change
//   out_toggled     flips on every accepted rising change
//   out_change_next high in the cycle before a strobe (feeds the parent's
//                   registered any-changed flag so it lines up with strobes)
// ---------------------------------------------------------------------------
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int   STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int   SYNC_STEPS   = DEFAULT_SYNC_STEPS,
    parameter logic INIT_VALUE   = 1'b0,
    parameter int   COUNTER_BITS = counter_bits(STABLE_TICKS)
) (
    input  logic in_clk,
    input  logic in_rst,
    input  logic in_signal,
    output logic out_debounced,
    output logic out_rising,
    output logic out_falling,
    output logic out_toggled,
    output logic out_change_next
);

    localparam logic [COUNTER_BITS-1:0] LAST_COUNT = COUNTER_BITS'(STABLE_TICKS - 1);

    logic [SYNC_STEPS-1:0]   sync_q;
    logic                    synced;
    logic [COUNTER_BITS-1:0] count_q;
    edge_kind_t              edge_kind;

    // Synchroniser chain: bit 0 samples the raw input, the top bit is the
    // metastability-filtered level that the rest of the channel uses
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            sync_q <= {SYNC_STEPS{INIT_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STEPS-2:0], in_signal};
        end
    end

    assign synced = sync_q[SYNC_STEPS-1];

    // A change is accepted when the synced level has differed from the
    // output for STABLE_TICKS consecutive edges, i.e. this is the last one
    always_comb begin
        edge_kind = EDGE_NONE;
        if ((synced != out_debounced) && (count_q == LAST_COUNT)) begin
            edge_kind = synced ? EDGE_RISE : EDGE_FALL;
        end
    end

    assign out_change_next = (edge_kind != EDGE_NONE);

    // Stable counter: any return to the current output level restarts the
    // count, and acceptance restarts it too, so the counter never wraps
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            count_q <= '0;
        end else if ((synced == out_debounced) || (count_q == LAST_COUNT)) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + COUNTER_BITS'(1);
        end
    end

    // Debounced level, single-cycle strobes and the push-button toggle,
    // all updated together on the accepting edge
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_debounced <= INIT_VALUE;
            out_rising    <= 1'b0;
            out_falling   <= 1'b0;
            out_toggled   <= 1'b0;
        end else begin
            out_rising  <= (edge_kind == EDGE_RISE);
            out_falling <= (edge_kind == EDGE_FALL);
            if (edge_kind != EDGE_NONE) begin
                out_debounced <= synced;
            end
            if (edge_kind == EDGE_RISE) begin
                out_toggled <= ~out_toggled;
            end
        end
    end

endmodule

// File: rtl/debounce_multi.sv
// ---------------------------------------------------------------------------
// debounce_multi
//
// Multi-channel switch/button debouncer. Each channel is an independent
// debounce_channel; the top level only adds the registered OR of all
// strobes.
//
// Ports:
//   in_clk           system clock
//   in_rst           asynchronous reset, active low
//   in_signals       raw asynchronous inputs, one bit per channel
//   out_debounced    accepted stable level per channel
//   out_rising       one-cycle strobe per channel on accepted 0->1
//   out_falling      one-cycle strobe per channel on accepted 1->0
//   out_toggled      per-channel push-button on/off state
//   out_any_changed  high in the same cycle as any rising/falling strobe
// ---------------------------------------------------------------------------
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int   NUM_CHANNELS = DEFAULT_NUM_CHANNELS,
    parameter int   STABLE_TICKS = DEFAULT_STABLE_TICKS,
    parameter int   SYNC_STEPS   = DEFAULT_SYNC_STEPS,
    parameter logic INIT_VALUE   = 1'b0,
    parameter int   COUNTER_BITS = counter_bits(STABLE_TICKS)
) (
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic [NUM_CHANNELS-1:0] in_signals,
    output logic [NUM_CHANNELS-1:0] out_debounced,
    output logic [NUM_CHANNELS-1:0] out_rising,
    output logic [NUM_CHANNELS-1:0] out_falling,
    output logic [NUM_CHANNELS-1:0] out_toggled,
    output logic                    out_any_changed
);

    logic [NUM_CHANNELS-1:0] change_next;

    for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_channel
        debounce_channel #(
            .STABLE_TICKS (STABLE_TICKS),
            .SYNC_STEPS   (SYNC_STEPS),
            .INIT_VALUE   (INIT_VALUE),
            .COUNTER_BITS (COUNTER_BITS)
        ) u_channel (
            .in_clk          (in_clk),
            .in_rst          (in_rst),
            .in_signal       (in_signals[i]),
            .out_debounced   (out_debounced[i]),
            .out_rising      (out_rising[i]),
            .out_falling     (out_falling[i]),
            .out_toggled     (out_toggled[i]),
            .out_change_next (change_next[i])
        );
    end

    // Registered from the channels' pre-edge acceptance so the flag appears
    // in exactly the cycle the strobes do, once regardless of channel count
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            out_any_changed <= 1'b0;
        end else begin
            out_any_changed <= |change_next;
        end
    end

endmodule

// File: tb/tb_debounce_multi.sv
// ---------------------------------------------------------------------------
// tb_debounce_multi
//
// Drives a default build (4 channels, 50 ticks, 3 sync steps) and a
// single-tick build of debounce_multi. A reference model records every
// captured input word and accepts a channel's new level once the last
// STABLE_TICKS synchronised samples all differ from its current output;
// expected events go into a queue that a monitor pops on the falling edge.
// ---------------------------------------------------------------------------
module tb_debounce_multi;

    localparam int NCH        = 4;
    localparam int TICKS      = 50;
    localparam int STEPS      = 3;
    localparam int FAST_TICKS = 1;
    localparam int VW         = 4 * NCH;

    logic           in_clk = 1'b0;
    logic           in_rst = 1'b0;
    logic [NCH-1:0] sig    = '0;
    logic [NCH-1:0] fsig   = '0;

    logic [NCH-1:0] out_debounced, out_rising, out_falling, out_toggled;
    logic           out_any_changed;
    logic [NCH-1:0] f_out_debounced, f_out_rising, f_out_falling, f_out_toggled;
    logic           f_out_any_changed;
    logic [VW-1:0]  dut_view, fast_view;

    int checks   = 0;
    int failures = 0;

    always #5 in_clk = ~in_clk;

    debounce_multi #(
        .NUM_CHANNELS (NCH),
        .STABLE_TICKS (TICKS),
        .SYNC_STEPS   (STEPS),
        .INIT_VALUE   (1'b0)
    ) u_dut (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_signals      (sig),
        .out_debounced   (out_debounced),
        .out_rising      (out_rising),
        .out_falling     (out_falling),
        .out_toggled     (out_toggled),
        .out_any_changed (out_any_changed)
    );

    debounce_multi #(
        .NUM_CHANNELS (NCH),
        .STABLE_TICKS (FAST_TICKS),
        .SYNC_STEPS   (STEPS),
        .INIT_VALUE   (1'b0)
    ) u_fast (
        .in_clk          (in_clk),
        .in_rst          (in_rst),
        .in_signals      (fsig),
        .out_debounced   (f_out_debounced),
        .out_rising      (f_out_rising),
        .out_falling     (f_out_falling),
        .out_toggled     (f_out_toggled),
        .out_any_changed (f_out_any_changed)
    );

    assign dut_view  = {out_debounced, out_rising, out_falling, out_toggled};
    assign fast_view = {f_out_debounced, f_out_rising, f_out_falling, f_out_toggled};

    // Compare one value and keep the tallies
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Drive a word on the falling edge and hold it for 'cycles' captures
    task automatic applyStimulus(input logic [NCH-1:0] value, input int cycles);
        @(negedge in_clk);
        sig = value;
        repeat (cycles - 1) @(negedge in_clk);
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [VW-1:0]  exp_q[$];
    logic [NCH-1:0] cap[$];
    logic [NCH-1:0] fcap[$];
    logic [NCH-1:0] m_deb, m_tog, m_rise, m_fall, m_word;
    logic [NCH-1:0] f_deb, f_tog, f_rise, f_fall, f_ev;
    logic           m_ok;
    int             m_lo, m_hi;

    // Each edge records the captured input; the sample the channel logic
    // judges on this edge is the one captured STEPS edges earlier
    always @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            cap    = {};
            fcap   = {};
            exp_q  = {};
            for (int k = 0; k < STEPS; k++) begin
                cap.push_back('0);
                fcap.push_back('0);
            end
            m_deb  = '0;
            m_tog  = '0;
            f_deb  = '0;
            f_tog  = '0;
            f_rise = '0;
            f_fall = '0;
        end else begin
            cap.push_back(sig);
            fcap.push_back(fsig);
            m_rise = '0;
            m_fall = '0;
            m_hi   = cap.size() - 1 - STEPS;
            m_lo   = m_hi - (TICKS - 1);
            for (int ch = 0; ch < NCH; ch++) begin
                m_ok = (m_lo >= 0);
                if (m_ok) begin
                    for (int j = m_lo; j <= m_hi; j++) begin
                        m_word = cap[j];
                        if (m_word[ch] == m_deb[ch]) m_ok = 1'b0;
                    end
                end
                if (m_ok) begin
                    if (m_deb[ch]) m_fall[ch] = 1'b1;
                    else           m_rise[ch] = 1'b1;
                end
            end
            m_deb = m_deb ^ (m_rise | m_fall);
            m_tog = m_tog ^ m_rise;
            if ((m_rise | m_fall) != '0) exp_q.push_back({m_deb, m_rise, m_fall, m_tog});
            while (cap.size() > TICKS + STEPS + 1) void'(cap.pop_front());

            f_ev   = fcap[fcap.size() - 1 - STEPS];
            f_rise = f_ev & ~f_deb;
            f_fall = ~f_ev & f_deb;
            f_deb  = f_ev;
            f_tog  = f_tog ^ f_rise;
            while (fcap.size() > STEPS + 1) void'(fcap.pop_front());
        end
    end

    // ------------------------------------------------------------------
    // Monitor: pops an expected event whenever one is due, otherwise
    // requires a quiet cycle at the model's current level
    // ------------------------------------------------------------------
    logic [VW-1:0] mon_exp;

    always @(negedge in_clk) begin
        if (!in_rst) begin
            checkOutput("reset_view", 32'(dut_view), 32'd0);
            checkOutput("reset_any", 32'(out_any_changed), 32'd0);
            checkOutput("fast_reset_view", 32'(fast_view), 32'd0);
        end else begin
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                checkOutput("event_view", 32'(dut_view), 32'(mon_exp));
                checkOutput("event_any", 32'(out_any_changed), 32'd1);
            end else begin
                checkOutput("idle_view", 32'(dut_view), 32'({m_deb, {NCH{1'b0}}, {NCH{1'b0}}, m_tog}));
                checkOutput("idle_any", 32'(out_any_changed), 32'd0);
            end
            checkOutput("fast_view", 32'(fast_view), 32'({f_deb, f_rise, f_fall, f_tog}));
            checkOutput("fast_any", 32'(f_out_any_changed), 32'(|(f_rise | f_fall)));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin
        int             edges;
        logic           seen;
        int             hold[NCH];
        logic [NCH-1:0] next;

        $display("[TB] start");

        // Reset, then 200 quiet cycles
        repeat (5) @(posedge in_clk);
        @(negedge in_clk);
        #2 in_rst = 1'b1;
        applyStimulus('0, 200);

        // Single-tick build: latency from capture edge is STEPS edges
        @(negedge in_clk);
        fsig[0] = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge in_clk);
            #1;
            edges++;
            if (f_out_rising[0]) seen = 1'b1;
        end
        checkOutput("fast_latency", 32'(edges - 1), 32'(STEPS));

        // Default build: clean 0->1 on channel 0
        @(negedge in_clk);
        sig[0] = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 100) begin
            @(posedge in_clk);
            #1;
            edges++;
            if (out_rising[0]) seen = 1'b1;
        end
        checkOutput("ch0_latency", 32'(edges - 1), 32'(TICKS + STEPS - 1));
        applyStimulus(4'b0001, 60);

        // Channel 1 bounces with a 10-cycle period, then settles high
        for (int b = 0; b < 50; b++) begin
            applyStimulus(4'b0011, 5);
            applyStimulus(4'b0001, 5);
        end
        applyStimulus(4'b0011, 100);

        // Channel 2: glitch one tick short, then exactly long enough
        applyStimulus(4'b0111, TICKS - 1);
        applyStimulus(4'b0011, 100);
        applyStimulus(4'b0111, TICKS);
        applyStimulus(4'b0011, 100);

        // All channels together, two full press/release cycles
        applyStimulus(4'b0000, 100);
        applyStimulus(4'b1111, 100);
        applyStimulus(4'b0000, 100);
        applyStimulus(4'b1111, 100);
        applyStimulus(4'b0000, 100);

        // Reset 30 cycles into a pending change; inputs held through reset
        fsig = 4'b1010;
        applyStimulus(4'b0111, 100);
        applyStimulus(4'b1111, 30);
        @(posedge in_clk);
        #3 in_rst = 1'b0;
        #1;
        checkOutput("async_reset_view", 32'(dut_view), 32'd0);
        checkOutput("async_reset_any", 32'(out_any_changed), 32'd0);
        checkOutput("async_reset_fast", 32'(fast_view), 32'd0);
        repeat (3) @(posedge in_clk);
        @(negedge in_clk);
        #2 in_rst = 1'b1;
        applyStimulus(4'b1111, 100);

        // Random hold times around the acceptance threshold
        for (int c = 0; c < NCH; c++) hold[c] = 0;
        next = sig;
        repeat (3000) begin
            for (int c = 0; c < NCH; c++) begin
                if (hold[c] == 0) begin
                    next[c] = ~next[c];
                    hold[c] = $urandom_range(120, 1);
                end else begin
                    hold[c] = hold[c] - 1;
                end
            end
            @(negedge in_clk);
            sig  = next;
            fsig = NCH'($urandom);
        end

        // Drain and finish
        fsig = '0;
        applyStimulus('0, 150);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
